// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, addresses a 1-cycle registered ROM,
// and presents {pc, instr} to decode over a valid/ready handshake.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch #(
  parameter int unsigned     ADDR_WIDTH = 12,
  parameter int unsigned     DATA_WIDTH = 32,
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_rdata,
  input  logic                  i_redirect_valid,
  input  logic [XLEN-1:0]       i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0]           o_fetch_cnt,
  output logic [31:0]           o_stall_cnt,
`endif
  output logic [DATA_WIDTH-1:0] o_instr
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_c;
  logic            fire_c;
  logic            stall_c;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

  // Next-state, next-PC and handshake decode; reset overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_c = 1'b0;
    fire_c  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      BOOT: begin
        // ROM is re-reading pc_q this cycle so its data is ready in RUN.
        state_d = RUN;
      end
      RUN: begin
        valid_c = !i_redirect_valid;
        fire_c  = valid_c & i_ready;
        stall_c = valid_c & !i_ready;
        if (i_redirect_valid) begin
          pc_d = i_redirect_pc & ALIGN_MSK;
        end else if (fire_c) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (i_rst) begin
      state_d = BOOT;
      pc_d    = RESET_PC;
      valid_c = 1'b0;
      fire_c  = 1'b0;
      stall_c = 1'b0;
    end
  end

`ifdef IFETCH_PERF_EN
  // Fetch / stall event counters, wrapping at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fire_c) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall_c) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall_c;
`endif

  // State and PC registers; pc_d already carries the reset value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // ROM is addressed with the PC that will be current next cycle.
  assign o_rom_addr = pc_d[ADDR_WIDTH+1:2];
  assign o_valid    = valid_c;
  assign o_pc       = pc_q;
  assign o_instr    = i_rom_rdata;

endmodule
